// File: rtl/rr_mux_arb.sv
// N-input to 1-output multiplexer with a registered output stage.
// The grant is either a fixed select index or round-robin over the valid inputs.
module rr_mux_arb #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        select,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic             gnt_any;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load_ok;
    logic             in_xfer;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (MODE == 0) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (int'(select) == i && in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            // Cyclic search starting just after the last granted channel
            for (int k = 1; k <= NUM_IN; k++) begin
                if (!gnt_any && in_valid[(int'(last_q) + k) % NUM_IN]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SEL_W'((int'(last_q) + k) % NUM_IN);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load_ok = !valid_q || out_ready;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = !reset && load_ok && gnt_any
                          && (gnt_idx == SEL_W'(i));
        end
    end

    assign in_xfer = |(in_valid & in_ready);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        src_d   = src_q;
        last_d  = last_q;
        if (in_xfer) begin
            data_d  = gnt_data;
            src_d   = gnt_idx;
            valid_d = 1'b1;
            last_d  = gnt_idx;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
            last_q  <= SEL_W'(NUM_IN - 1);
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_src   = src_q;

endmodule
